psum_drain_fifo: RTL and testbench



---
 rtl/psum_drain_fifo_if.sv | 26 ++
 rtl/psum_drain_fifo.sv | 104 ++++++++++
 tb/tb_psum_drain_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_fifo_if.sv
// rtl/psum_drain_fifo_if.sv - row/lane handshake bundle between MAC array, drain FIFO and output stage
interface psum_drain_fifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in_psum;
  logic [col-1:0]         wr;
  logic                   rd;
  logic                   relu_en;
  logic [psum_bw*col-1:0] out_psum;
  logic                   out_strobe;
  logic                   o_ready;
  logic                   o_full;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output in_psum, wr, rd, relu_en,
    input  out_psum, out_strobe, o_ready, o_full, overflow, underflow
  );

  modport slave (
    input  in_psum, wr, rd, relu_en,
    output out_psum, out_strobe, o_ready, o_full, overflow, underflow
  );
endinterface

// File: rtl/psum_drain_fifo.sv
// rtl/psum_drain_fifo.sv - per-column psum drain FIFO delivering aligned rows with optional ReLU
module psum_drain_fifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  psum_drain_fifo_if.slave   bus
);
  localparam int AW = $clog2(depth);
  typedef logic [AW:0] ptr_t;

  ptr_t                   wptr_q [col];
  ptr_t                   wptr_d [col];
  ptr_t                   rptr_q [col];
  ptr_t                   rptr_d [col];
  logic [psum_bw-1:0]     mem_q  [col][depth];

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         wr_ok;
  logic                   ready;
  logic                   pop;
  logic [psum_bw-1:0]     head;

  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   strobe_q, strobe_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  // Pointer MSB acts as a lap bit so full and empty are distinguishable.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < col; c++) begin
      empty[c] = (wptr_q[c] == rptr_q[c]);
      full[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                 (wptr_q[c][AW] != rptr_q[c][AW]);
    end
  end

  assign ready = ~|empty;
  assign pop   = bus.rd && ready;

  always_comb begin
    out_d    = out_q;
    strobe_d = pop;
    ovf_d    = ovf_q;
    unf_d    = unf_q | (bus.rd & ~ready);
    wr_ok    = '0;
    head     = '0;
    for (int c = 0; c < col; c++) begin
      // A pop frees a slot this cycle, so a full lane can still accept a write.
      wr_ok[c] = bus.wr[c] && (!full[c] || pop);
      if (bus.wr[c] && full[c] && !pop) begin
        ovf_d = 1'b1;
      end
      wptr_d[c] = wptr_q[c] + ptr_t'(wr_ok[c]);
      rptr_d[c] = rptr_q[c] + ptr_t'(pop);
      head      = mem_q[c][rptr_q[c][AW-1:0]];
      if (pop) begin
        out_d[c*psum_bw +: psum_bw] = (bus.relu_en && head[psum_bw-1]) ? '0 : head;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      out_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      out_q    <= out_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_ok[c]) begin
        mem_q[c][wptr_q[c][AW-1:0]] <= bus.in_psum[c*psum_bw +: psum_bw];
      end
    end
  end

  assign bus.out_psum   = out_q;
  assign bus.out_strobe = strobe_q;
  assign bus.o_ready    = ready;
  assign bus.o_full     = |full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_psum_drain_fifo.sv
// tb/tb_psum_drain_fifo.sv - self-checking bench for psum_drain_fifo against a queue model
module tb_psum_drain_fifo;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_drain_fifo_if #(.col(COL), .psum_bw(BW)) bus();
  psum_drain_fifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [BW-1:0]     mq [COL][$];
  logic [BW*COL-1:0] m_out;
  logic              m_strobe, m_ovf, m_unf;

  typedef struct {
    logic [BW*COL-1:0] row;
    logic              relu;
    logic [BW*COL-1:0] exp;
  } relu_vec_t;
  relu_vec_t tv [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) mq[c].delete();
    m_out = '0; m_strobe = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic [COL-1:0] wr, input logic [BW*COL-1:0] data,
                            input logic rd, input logic relu);
    logic [BW-1:0] v;
    bit rdy;
    rdy = m_ready();
    m_strobe = 1'b0;
    if (rd && rdy) begin
      m_strobe = 1'b1;
      for (int c = 0; c < COL; c++) begin
        v = mq[c].pop_front();
        m_out[c*BW +: BW] = (relu && v[BW-1]) ? '0 : v;
      end
    end else if (rd) begin
      m_unf = 1'b1;
    end
    for (int c = 0; c < COL; c++) begin
      if (wr[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(data[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"},  bus.o_ready,    m_ready());
    chk({tag, ".full"},   bus.o_full,     m_full());
    chk({tag, ".ovf"},    bus.overflow,   m_ovf);
    chk({tag, ".unf"},    bus.underflow,  m_unf);
    chk({tag, ".strobe"}, bus.out_strobe, m_strobe);
    chk({tag, ".out"},    bus.out_psum,   m_out);
  endtask

  task automatic cyc(input string tag, input logic [COL-1:0] wr, input logic [BW*COL-1:0] data,
                     input logic rd, input logic relu);
    bus.wr = wr; bus.in_psum = data; bus.rd = rd; bus.relu_en = relu;
    @(posedge clk); #1;
    model_step(wr, data, rd, relu);
    bus.wr = '0; bus.rd = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    bus.wr = '0; bus.rd = 1'b0; bus.relu_en = 1'b0; bus.in_psum = '0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all({tag, ".async"});
    chk({tag, ".rdy0"}, bus.o_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_all({tag, ".rel"});
  endtask

  function automatic logic [BW*COL-1:0] row_of(input int base, input int step);
    logic [BW*COL-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + c * step);
    return r;
  endfunction

  function automatic logic [BW*COL-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [BW*COL-1:0] r;
    logic [BW*COL-1:0] rows [DEPTH];

    tv[0].row  = {16'hC000, 16'h4000, 16'hFFFF, 16'h0001, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFF0};
    tv[0].relu = 1'b1;
    tv[0].exp  = {16'h0000, 16'h4000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    tv[1].row  = tv[0].row;
    tv[1].relu = 1'b0;
    tv[1].exp  = tv[0].row;
    tv[2].row  = {8{16'h8000}};
    tv[2].relu = 1'b1;
    tv[2].exp  = '0;
    tv[3].row  = {8{16'h7FFF}};
    tv[3].relu = 1'b1;
    tv[3].exp  = {8{16'h7FFF}};

    reset = 1'b1;
    bus.wr = '0; bus.rd = 1'b0; bus.relu_en = 1'b0; bus.in_psum = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // Skewed column drain, one lane per cycle.
    r = row_of(16'h0010, 1);
    for (int c = 0; c < COL; c++) begin
      cyc("skew_wr", COL'(1 << c), r, 1'b0, 1'b0);
      chk("skew_ready", bus.o_ready, (c == COL - 1));
    end
    cyc("skew_rd", '0, '0, 1'b1, 1'b0);
    chk("skew_strobe", bus.out_strobe, 1'b1);
    chk("skew_out", bus.out_psum, r);
    chk("skew_ready_drop", bus.o_ready, 1'b0);
    cyc("skew_idle", '0, '0, 1'b0, 1'b0);
    chk("skew_strobe_1cyc", bus.out_strobe, 1'b0);

    // Fill every lane, overflow lane 3, then drain in order.
    do_reset("rst_ovf");
    for (int i = 0; i < DEPTH; i++) begin
      r = row_of(16'h0100 + i * 16, 1);
      r[3*BW +: BW] = BW'(i);
      cyc("fill", 8'hFF, r, 1'b0, 1'b0);
    end
    chk("fill_full", bus.o_full, 1'b1);
    r = '0; r[3*BW +: BW] = 16'hDEAD;
    cyc("ovf_wr", 8'h08, r, 1'b0, 1'b0);
    chk("ovf_set", bus.overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("drain", '0, '0, 1'b1, 1'b0);
      chk("drain_lane3", bus.out_psum[3*BW +: BW], BW'(i));
    end
    chk("drain_empty", bus.o_ready, 1'b0);

    // Full lanes with simultaneous write and pop.
    do_reset("rst_wrrd");
    for (int i = 0; i < DEPTH; i++) begin
      rows[i] = rnd_row();
      cyc("fill2", 8'hFF, rows[i], 1'b0, 1'b0);
    end
    cyc("wrrd_full", 8'hFF, rnd_row(), 1'b1, 1'b0);
    chk("wrrd_no_ovf", bus.overflow, 1'b0);
    chk("wrrd_still_full", bus.o_full, 1'b1);
    chk("wrrd_oldest", bus.out_psum, rows[0]);
    for (int i = 0; i < DEPTH; i++) cyc("drain2", '0, '0, 1'b1, 1'b0);

    // ReLU vectors.
    for (int k = 0; k < 4; k++) begin
      cyc("relu_wr", 8'hFF, tv[k].row, 1'b0, 1'b0);
      cyc("relu_rd", '0, '0, 1'b1, tv[k].relu);
      chk($sformatf("relu_vec%0d", k), bus.out_psum, tv[k].exp);
    end

    // Underflow with lane 5 empty, then write-to-empty alongside rd.
    do_reset("rst_unf");
    r = rnd_row();
    cyc("unf_wr", 8'hDF, r, 1'b0, 1'b0);
    cyc("unf_rd", '0, '0, 1'b1, 1'b0);
    chk("unf_set", bus.underflow, 1'b1);
    chk("unf_nostrobe", bus.out_strobe, 1'b0);
    cyc("unf_wr5_rd", 8'h20, rnd_row(), 1'b1, 1'b0);
    chk("unf_ready", bus.o_ready, 1'b1);
    chk("unf_nostrobe2", bus.out_strobe, 1'b0);
    cyc("unf_pop", '0, '0, 1'b1, 1'b0);
    chk("unf_lane0", bus.out_psum[BW-1:0], r[BW-1:0]);

    // Reset mid-stream, then wrap pointers.
    for (int i = 0; i < 3; i++) cyc("pre_rst", 8'hFF, rnd_row(), 1'b0, 1'b0);
    do_reset("rst_mid");
    chk("rst_out0", bus.out_psum, '0);
    chk("rst_unf0", bus.underflow, 1'b0);
    for (int i = 0; i < 20; i++) begin
      r = rnd_row();
      cyc("wrap_wr", 8'hFF, r, 1'b0, 1'b0);
      cyc("wrap_rd", '0, '0, 1'b1, 1'b0);
      chk("wrap_out", bus.out_psum, r);
    end

    // Randomized traffic.
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", COL'($urandom), rnd_row(), ($urandom_range(0, 9) < 4), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
